fetch_unit: RTL and testbench

Instruction fetch front end that walks the program counter, issues single-outstanding read requests to instruction memory, and pushes each returned `{pc, inst}` pair into the downstream fetch queue (the 2^n-entry synchronous FIFO feeding decode). It owns the redirect path: a branch or trap redirect reloads the PC, kills the queue contents, and discards any response still in flight for the old path.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-outstanding memory reads pushed as {pc, inst} into the
// fetch queue, with redirect/kill handling. Define FETCH_PERF_COUNTER_EN for perf counters.
module fetch_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned INST_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [XLEN-1:0]            mem_req_addr,
    input  logic                       mem_resp_valid,
    input  logic [INST_WIDTH-1:0]      mem_resp_data,
    input  logic                       q_wready,
    output logic                       q_wvalid,
    output logic [XLEN+INST_WIDTH-1:0] q_wdata,
    output logic                       q_kill
`ifdef FETCH_PERF_COUNTER_EN
    ,
    output logic [31:0]                perf_fetched,
    output logic [31:0]                perf_discarded
`endif
);

    localparam logic [XLEN-1:0] ResetPcX = XLEN'(RESET_PC);

    typedef enum logic [1:0] {StRun, StWait, StPush, StDiscard} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [XLEN-1:0]       r_pc;
    logic [XLEN-1:0]       w_pc_next;
    logic [XLEN-1:0]       r_buf_pc;
    logic [INST_WIDTH-1:0] r_buf_inst;

    logic w_req_fire;
    logic w_push_fire;
    logic w_resp_take;
    logic w_resp_drop;

    assign w_req_fire  = mem_req_valid && mem_req_ready;
    assign w_push_fire = q_wvalid && q_wready;
    assign w_resp_take = (r_state == StWait) && mem_resp_valid && !redirect_valid;
    // Dropped responses: abandoned in WAIT by a coincident redirect, or the one DISCARD awaits.
    assign w_resp_drop = mem_resp_valid &&
                         (((r_state == StWait) && redirect_valid) || (r_state == StDiscard));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StRun;
            r_pc       <= ResetPcX;
            r_buf_pc   <= '0;
            r_buf_inst <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_req_fire) begin
                r_buf_pc <= r_pc;
            end
            if (w_resp_take) begin
                r_buf_inst <= mem_resp_data;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StRun: begin
                if (w_req_fire) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (redirect_valid) begin
                    w_state_next = mem_resp_valid ? StRun : StDiscard;
                end else if (mem_resp_valid) begin
                    w_state_next = StPush;
                end
            end
            StPush: begin
                if (redirect_valid || w_push_fire) begin
                    w_state_next = StRun;
                end
            end
            StDiscard: begin
                // The awaited response is consumed even if a redirect lands on the same cycle.
                if (mem_resp_valid) begin
                    w_state_next = StRun;
                end
            end
            default: w_state_next = StRun;
        endcase
    end

    always_comb begin
        w_pc_next = r_pc;
        if (redirect_valid) begin
            w_pc_next = redirect_pc;
        end else if (w_push_fire) begin
            w_pc_next = r_pc + XLEN'(4);
        end
    end

    always_comb begin
        mem_req_valid = rst_n && (r_state == StRun) && !redirect_valid;
        mem_req_addr  = r_pc;
        q_wvalid      = rst_n && (r_state == StPush) && !redirect_valid;
        q_wdata       = {r_buf_pc, r_buf_inst};
        q_kill        = redirect_valid;
    end

`ifdef FETCH_PERF_COUNTER_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_discarded;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_fetched   <= '0;
            r_perf_discarded <= '0;
        end else begin
            if (w_push_fire) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_resp_drop) begin
                r_perf_discarded <= r_perf_discarded + 32'd1;
            end
        end
    end

    assign perf_fetched   = r_perf_fetched;
    assign perf_discarded = r_perf_discarded;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_resp_drop;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, checked against a
// transaction-level model of the fetch stream (expected PC, outstanding request, counters).
module tb_fetch_unit;

    localparam logic [31:0] RstPc = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        q_wready;
    logic        q_wvalid;
    logic [63:0] q_wdata;
    logic        q_kill;
`ifdef FETCH_PERF_COUNTER_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_discarded;
`endif

    fetch_unit #(
        .XLEN       (32),
        .INST_WIDTH (32),
        .RESET_PC   (RstPc)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .q_wready       (q_wready),
        .q_wvalid       (q_wvalid),
        .q_wdata        (q_wdata),
        .q_kill         (q_kill)
`ifdef FETCH_PERF_COUNTER_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_discarded (perf_discarded)
`endif
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model state
    logic [31:0] exp_pc;
    logic        pend;
    logic [31:0] pend_addr;
    int unsigned pend_cnt;
    logic        doomed;
    logic        stale;
    logic        rst_seen = 1'b0;
    int unsigned lat = 1;
    int unsigned fetched_exp;
    int unsigned disc_exp;
    int unsigned n_push;

    // What happened in the most recent cycle
    logic        last_req_hs, last_push_hs, last_req_valid, last_wvalid, last_kill;
    logic [31:0] last_addr;
    logic [63:0] last_wdata;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive inputs, sample, check, advance the model past the next posedge.
    task automatic cycle(input logic rst, input logic rv, input logic [31:0] rpc,
                         input logic rdy, input logic wr);
        logic        resp, req_hs, push_hs, pend_before;
        logic [31:0] junk;
        if (pend && pend_cnt > 0) pend_cnt--;
        resp = pend && (pend_cnt == 0);
        junk = $urandom;
        rst_n          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        mem_req_ready  = rdy && !stale;
        q_wready       = wr;
        mem_resp_valid = resp;
        mem_resp_data  = resp ? inst_of(pend_addr) : junk;
        #1;
`ifdef FETCH_PERF_COUNTER_EN
        if (rst_seen) begin
            chk("perf_fetched", perf_fetched, fetched_exp);
            chk("perf_discarded", perf_discarded, disc_exp);
        end
`endif
        chk("kill", q_kill, rv);
        if (!rst) chk("rst_outs", {mem_req_valid, q_wvalid}, 2'b00);
        if (rv) chk("redirect_gate", {mem_req_valid, q_wvalid}, 2'b00);
        req_hs         = mem_req_valid && mem_req_ready;
        push_hs        = q_wvalid && q_wready;
        last_req_hs    = req_hs;
        last_push_hs   = push_hs;
        last_req_valid = mem_req_valid;
        last_wvalid    = q_wvalid;
        last_kill      = q_kill;
        last_addr      = mem_req_addr;
        last_wdata     = q_wdata;
        pend_before    = pend;
        if (!rst) begin
            rst_seen    = 1'b1;
            exp_pc      = RstPc;
            fetched_exp = 0;
            disc_exp    = 0;
            if (pend && !resp) stale = 1'b1;
            doomed = 1'b0;
        end else begin
            if (push_hs) begin
                chk("push_data", q_wdata, {exp_pc, inst_of(exp_pc)});
                exp_pc = exp_pc + 32'd4;
                fetched_exp++;
                n_push++;
            end
            if (req_hs) begin
                chk("req_addr", mem_req_addr, exp_pc);
                chk("one_outstanding", pend_before, 1'b0);
            end
            if (resp && !stale && (doomed || rv)) disc_exp++;
            if (rv && pend && !resp && !stale) doomed = 1'b1;
            if (rv) exp_pc = rpc;
        end
        if (resp) begin
            pend   = 1'b0;
            doomed = 1'b0;
            stale  = 1'b0;
        end
        if (req_hs && rst) begin
            pend      = 1'b1;
            pend_addr = mem_req_addr;
            pend_cnt  = lat;
        end
        @(negedge clk);
    endtask

    task automatic run(input int unsigned n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [31:0] rpc;
        logic        rv;
        int unsigned base;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = '0; q_wready = 1'b0;
        exp_pc = RstPc; pend = 1'b0; pend_addr = '0; pend_cnt = 0; doomed = 1'b0;
        stale = 1'b0; fetched_exp = 0; disc_exp = 0; n_push = 0;
        @(negedge clk);

        // Straight-line fetch: req / resp / push every 3 cycles from RESET_PC
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            chk("seq_req", last_req_hs, (i % 3) == 0);
            chk("seq_push", last_push_hs, (i % 3) == 2);
            if (i == 0) chk("first_addr", last_addr, RstPc);
        end

        // Queue backpressure while holding {104, I1}
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        run(5);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            chk("stall_wvalid", last_wvalid, 1'b1);
            chk("stall_wdata", last_wdata, {32'h104, inst_of(32'h104)});
            chk("stall_noreq", last_req_valid, 1'b0);
        end
        run(1);
        chk("stall_release_push", last_push_hs, 1'b1);
        run(1);
        chk("after_stall_req", {last_req_hs, last_addr}, {1'b1, 32'h108});
        run(2);
        chk("push_108", last_push_hs, 1'b1);

        // Redirect in WAIT, response 3 cycles later
        lat = 4;
        run(1);
        chk("req_10c", {last_req_hs, last_addr}, {1'b1, 32'h10C});
        cycle(1'b1, 1'b1, 32'h2000, 1'b1, 1'b1);
        chk("wait_redir_kill", last_kill, 1'b1);
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            run(1);
            chk("discard_quiet", {last_req_valid, last_push_hs, last_kill}, 3'b000);
        end
        run(1);
        chk("req_2000", {last_req_hs, last_addr}, {1'b1, 32'h2000});
`ifdef FETCH_PERF_COUNTER_EN
        chk("perf_disc_one", perf_discarded, 32'd1);
`endif

        // Redirect coincident with response in WAIT
        cycle(1'b1, 1'b1, 32'h3000, 1'b1, 1'b1);
        chk("coinc_nopush", last_push_hs, 1'b0);
        run(1);
        chk("req_3000", {last_req_hs, last_addr}, {1'b1, 32'h3000});
        run(1);

        // Redirect in PUSH
        cycle(1'b1, 1'b1, 32'h4000, 1'b1, 1'b1);
        chk("push_redir_nopush", {last_wvalid, last_push_hs}, 2'b00);
        run(1);
        chk("req_4000", {last_req_hs, last_addr}, {1'b1, 32'h4000});
        run(2);
        chk("push_4000", last_push_hs, 1'b1);

        // PC wrap
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        chk("run_redir_noreq", last_req_valid, 1'b0);
        run(1);
        chk("req_fffc", {last_req_hs, last_addr}, {1'b1, 32'hFFFF_FFFC});
        run(2);
        chk("push_fffc", {last_push_hs, last_wdata},
            {1'b1, 32'hFFFF_FFFC, inst_of(32'hFFFF_FFFC)});
        lat = 3;
        run(1);
        chk("req_wrap0", {last_req_hs, last_addr}, {1'b1, 32'h0});

        // Reset while in WAIT; stale response arrives after release
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        lat = 1;
        run(1);
        chk("post_rst_req", {last_req_valid, last_addr}, {1'b1, RstPc});
`ifdef FETCH_PERF_COUNTER_EN
        chk("post_rst_perf", {perf_fetched, perf_discarded}, 64'h0);
`endif
        run(1);
        chk("stale_ignored", last_push_hs, 1'b0);
        run(1);
        chk("req_after_stale", {last_req_hs, last_addr}, {1'b1, RstPc});
        run(2);
        chk("push_after_stale", {last_push_hs, last_wdata}, {1'b1, RstPc, inst_of(RstPc)});

        // Random traffic
        base = n_push;
        for (int i = 0; i < 2000; i++) begin
            lat = $urandom_range(1, 4);
            rnd = $urandom;
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + (rnd & 32'hC))
                                              : (rnd & 32'hFFFF_FFFC);
            rv  = ($urandom_range(0, 19) == 0);
            cycle(($urandom_range(0, 199) != 0), rv, rpc, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) < 7));
        end
        chk("progress", (n_push - base) >= 50, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
